// File: rtl/gray_rom_arbiter_pkg.sv
// rtl/gray_rom_arbiter_pkg.sv - shared widths and tag type for the gray ROM arbiter
//
// Purpose : common localparams and the in-flight tag record used by the
//           arbiter top and its round-robin grant logic.
// Contents: ADDR_W / DATA_W / CNT_W widths, TAG_ID_W storage width for the
//           requester id, tag_t {vld, id} and an idle tag constant.
package gray_rom_arbiter_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int CNT_W    = 16;
  // Wide enough for any legal ID_W; the top truncates to ID_W on output.
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{vld: 1'b0, id: '0};

endpackage

// File: rtl/gray_rom_arbiter_rr_arbiter.sv
// rtl/gray_rom_arbiter_rr_arbiter.sv - combinational round-robin / fixed-priority grant
//
// Purpose : picks one requester per cycle.
//   Round-robin: first requesting index at or above i_ptr, wrapping upward.
//   Fixed      : lowest requesting index.
// Ports   :
//   i_req    [NUM_REQ]  request vector (already gated by enable)
//   i_ptr    [ID_W]     round-robin start index
//   i_fixed  [1]        1 = fixed priority, 0 = round-robin
//   o_grant  [NUM_REQ]  one-hot grant, zero when nothing requests
//   o_winner [ID_W]     encoded index of the granted requester (0 when none)
module rr_arbiter
  import gray_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_fixed,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winner
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_req;
  logic [NUM_REQ-1:0] pick_src;
  logic               found;

  // Indices at or above the pointer form the first search window; if none of
  // them request, the wrap-around is simply the lowest request overall.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i >= int'(i_ptr));
    end
  end

  always_comb begin
    hi_req   = i_req & hi_mask;
    pick_src = (i_fixed || (hi_req == '0)) ? i_req : hi_req;
  end

  // Lowest set bit of pick_src.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_src[i] && !found) begin
        found      = 1'b1;
        o_grant[i] = 1'b1;
        o_winner   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/gray_rom_arbiter.sv
// rtl/gray_rom_arbiter.sv - shares one gray-code lookup ROM among NUM_REQ requesters
//
// Purpose : grants one lookup per clock, drives the ROM address, carries the
//           requester id alongside the fixed ROM read latency and returns each
//           result tagged with its owner.
// Ports   :
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_en                    0 blocks new grants; in-flight lookups still finish
//   i_cfg_fixed             1 = fixed priority (lowest index), 0 = round-robin
//   i_req_vld  [NUM_REQ]    per-requester request
//   i_req_addr [NUM_REQ*8]  requester n address in bits [n*8+7:n*8]
//   o_req_rdy  [NUM_REQ]    one-hot grant; accept = vld & rdy
//   o_rom_addr [8]          ROM address (holds last granted address when idle)
//   i_rom_data [8]          ROM data, valid RD_LAT clocks after the address
//   o_rsp_vld/id/data       registered response, one pulse per accept
//   o_busy                  any lookup in flight or response being presented
//   o_grant_cnt [16]        saturating count of accepted lookups
module gray_rom_arbiter
  import gray_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int RD_LAT  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_cfg_fixed,
  input  logic [NUM_REQ-1:0]        i_req_vld,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]        o_req_rdy,
  output logic [ADDR_W-1:0]         o_rom_addr,
  input  logic [DATA_W-1:0]         i_rom_data,
  output logic                      o_rsp_vld,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_busy,
  output logic [CNT_W-1:0]          o_grant_cnt
);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  tag_t               tag_q [RD_LAT];
  tag_t               tag_d [RD_LAT];
  tag_t               tag_last;
  logic               rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Enable gates the requests before arbitration so a disabled arbiter
  // presents no grant at all.
  assign arb_req = i_en ? i_req_vld : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req    (arb_req),
    .i_ptr    (ptr_q),
    .i_fixed  (i_cfg_fixed),
    .o_grant  (grant),
    .o_winner (winner)
  );

  always_comb begin
    accept   = |grant;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = i_req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign o_req_rdy  = grant;
  // Idle cycles keep the last granted address so the ROM address bus is quiet.
  assign o_rom_addr = accept ? sel_addr : addr_q;

  // Round-robin pointer moves past the winner; fixed mode leaves it alone so
  // switching back to round-robin resumes where it left off.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && !i_cfg_fixed) begin
      ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (accept) begin
      addr_d = sel_addr;
    end
  end

  // Tag shift register: stage 0 mirrors the address cycle, the last stage
  // lines up with the ROM data for that address.
  always_comb begin
    tag_d[0] = '{vld: accept, id: TAG_ID_W'(winner)};
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign tag_last = tag_q[RD_LAT-1];

  always_comb begin
    rsp_vld_d  = 1'b0;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (tag_last.vld) begin
      rsp_vld_d  = 1'b1;
      rsp_id_d   = tag_last.id[ID_W-1:0];
      rsp_data_d = i_rom_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q      <= '0;
      addr_q     <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= TAG_IDLE;
      end
    end else begin
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  always_comb begin
    o_busy = rsp_vld_q;
    for (int i = 0; i < RD_LAT; i++) begin
      o_busy = o_busy | tag_q[i].vld;
    end
  end

  assign o_rsp_vld   = rsp_vld_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_grant_cnt = cnt_q;

endmodule

// File: tb/tb_gray_rom_arbiter.sv
// tb/tb_gray_rom_arbiter.sv - randomized self-checking bench for gray_rom_arbiter
module tb_gray_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int RD_LAT  = 2;

  logic                  clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_en;
  logic                  i_cfg_fixed;
  logic [NUM_REQ-1:0]    i_req_vld;
  logic [NUM_REQ*8-1:0]  i_req_addr;
  logic [NUM_REQ-1:0]    o_req_rdy;
  logic [7:0]            o_rom_addr;
  logic [7:0]            i_rom_data;
  logic                  o_rsp_vld;
  logic [ID_W-1:0]       o_rsp_id;
  logic [7:0]            o_rsp_data;
  logic                  o_busy;
  logic [15:0]           o_grant_cnt;

  always #10 clk = ~clk;

  gray_rom_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_cfg_fixed (i_cfg_fixed),
    .i_req_vld   (i_req_vld),
    .i_req_addr  (i_req_addr),
    .o_req_rdy   (o_req_rdy),
    .o_rom_addr  (o_rom_addr),
    .i_rom_data  (i_rom_data),
    .o_rsp_vld   (o_rsp_vld),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_data  (o_rsp_data),
    .o_busy      (o_busy),
    .o_grant_cnt (o_grant_cnt)
  );

  function automatic logic [7:0] gray(input logic [7:0] a);
    return a ^ (a >> 1);
  endfunction

  // ROM behavioural model: data for an address appears RD_LAT clocks later.
  logic [7:0] rom_pipe [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) rom_pipe[i] = 8'h00;
  always @(posedge clk) begin
    rom_pipe[0] <= gray(o_rom_addr);
    for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign i_rom_data = rom_pipe[RD_LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    int due;
    int id;
    int data;
  } rsp_t;

  rsp_t               pend[$];
  int                 m_ptr;
  int                 m_cnt;
  int                 m_rsp_id;
  int                 m_rsp_data;
  int                 m_last_addr;
  bit                 m_addr_known;
  logic [NUM_REQ-1:0] m_last_rdy;
  int                 cyc = 0;

  // Winner = requester with the smallest rotational distance from the
  // pointer (round-robin) or the smallest index (fixed).
  function automatic int model_winner(input bit en, input bit fixed, input logic [NUM_REQ-1:0] vld);
    int best  = -1;
    int bestd = NUM_REQ;
    int d;
    if (!en) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vld[i]) begin
        d = fixed ? i : (i - m_ptr + NUM_REQ) % NUM_REQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_ptr        = 0;
    m_cnt        = 0;
    m_rsp_id     = 0;
    m_rsp_data   = 0;
    m_addr_known = 0;
    m_last_rdy   = '0;
  endtask

  task automatic do_reset();
    i_rst_n     = 1'b0;
    i_en        = 1'b1;
    i_cfg_fixed = 1'b0;
    i_req_vld   = '1;
    i_req_addr  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rsp_vld",  32'(o_rsp_vld),   32'(0));
    check("rst_rsp_id",   32'(o_rsp_id),    32'(0));
    check("rst_rsp_data", 32'(o_rsp_data),  32'(0));
    check("rst_busy",     32'(o_busy),      32'(0));
    check("rst_cnt",      32'(o_grant_cnt), 32'(0));
    check("rst_ptr_rdy",  32'(o_req_rdy),   32'(1));
    i_req_vld = '0;
    i_rst_n   = 1'b1;
    model_reset();
  endtask

  // One clock: check registered outputs, drive inputs, check the grant.
  task automatic step(input bit en, input bit fixed, input logic [NUM_REQ-1:0] vld,
                      input logic [NUM_REQ*8-1:0] addr);
    int w;
    logic [NUM_REQ-1:0] exp_rdy;
    bit exp_vld;
    @(negedge clk);
    cyc++;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    exp_vld = (pend.size() > 0) && (pend[0].due == cyc);
    if (exp_vld) begin
      m_rsp_id   = pend[0].id;
      m_rsp_data = pend[0].data;
    end
    check("rsp_vld",  32'(o_rsp_vld),   32'(exp_vld));
    check("rsp_id",   32'(o_rsp_id),    32'(m_rsp_id));
    check("rsp_data", 32'(o_rsp_data),  32'(m_rsp_data));
    check("busy",     32'(o_busy),      32'(pend.size() > 0));
    check("cnt",      32'(o_grant_cnt), 32'(m_cnt));

    i_en        = en;
    i_cfg_fixed = fixed;
    i_req_vld   = vld;
    i_req_addr  = addr;
    #1;
    w       = model_winner(en, fixed, vld);
    exp_rdy = (w >= 0) ? NUM_REQ'(1 << w) : '0;
    check("req_rdy", 32'(o_req_rdy), 32'(exp_rdy));
    if (w >= 0) begin
      m_last_addr  = int'(addr[w*8 +: 8]);
      m_addr_known = 1;
    end
    if (m_addr_known) check("rom_addr", 32'(o_rom_addr), 32'(m_last_addr));
    if (w >= 0) begin
      pend.push_back('{due: cyc + RD_LAT + 1, id: w, data: int'(gray(addr[w*8 +: 8]))});
      if (m_cnt < 65535) m_cnt++;
      if (!fixed) m_ptr = (w + 1) % NUM_REQ;
    end
    m_last_rdy = exp_rdy;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, '0, '0);
  endtask

  logic [NUM_REQ-1:0]   rv;
  logic [NUM_REQ*8-1:0] ra;
  bit                   ren;
  bit                   rfix;

  initial begin
    i_rst_n     = 1'b0;
    i_en        = 1'b0;
    i_cfg_fixed = 1'b0;
    i_req_vld   = '0;
    i_req_addr  = '0;
    model_reset();

    // Round-robin fairness from reset
    do_reset();
    repeat (12) step(1'b1, 1'b0, 4'hF, {8'h80, 8'hFF, 8'h0A, 8'h00});
    idle(5);

    // Single request
    do_reset();
    step(1'b1, 1'b0, 4'b0001, 32'h0000_0005);
    idle(5);
    check("single_cnt", 32'(o_grant_cnt), 32'(1));

    // Fixed priority: req1 starves req3 until it drops
    repeat (6) step(1'b1, 1'b1, 4'b1010, 32'h3300_1100);
    repeat (3) step(1'b1, 1'b1, 4'b1000, 32'h3300_1100);
    idle(5);

    // Enable gating after two accepts
    repeat (2) step(1'b1, 1'b0, 4'b0011, 32'h0000_2221);
    repeat (6) step(1'b0, 1'b0, 4'b0011, 32'h0000_2221);

    // Asynchronous reset one cycle after an accept
    do_reset();
    step(1'b1, 1'b0, 4'b0001, 32'h0000_0042);
    @(posedge clk);
    #1;
    check("prerst_busy", 32'(o_busy),      32'(1));
    check("prerst_cnt",  32'(o_grant_cnt), 32'(1));
    #1;
    i_rst_n   = 1'b0;
    i_req_vld = '0;
    #1;
    check("arst_rsp_vld", 32'(o_rsp_vld),   32'(0));
    check("arst_busy",    32'(o_busy),      32'(0));
    check("arst_cnt",     32'(o_grant_cnt), 32'(0));
    @(negedge clk);
    i_rst_n = 1'b1;
    model_reset();
    idle(6);

    // Randomized traffic following the hold-until-accepted rule
    rv   = '0;
    ra   = '0;
    rfix = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      ren = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) rfix = ~rfix;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rv[i] && m_last_rdy[i]) begin
          rv[i]          = 1'($urandom_range(0, 1));
          ra[i*8 +: 8]   = 8'($urandom);
        end else if (rv[i]) begin
          if ($urandom_range(0, 15) == 0) rv[i] = 1'b0;
        end else begin
          rv[i] = 1'($urandom_range(0, 1));
          if (rv[i]) ra[i*8 +: 8] = 8'($urandom);
        end
      end
      step(ren, rfix, rv, ra);
    end
    idle(6);

    // Counter saturation: bulk accepts, then cross 16'hFFFF under checking
    do_reset();
    i_en        = 1'b1;
    i_cfg_fixed = 1'b1;
    i_req_vld   = 4'b0001;
    i_req_addr  = 32'h0000_005A;
    repeat (65533) @(posedge clk);
    @(negedge clk);
    i_req_vld = '0;
    repeat (RD_LAT + 3) @(negedge clk);
    #1;
    check("sat_pre_cnt",  32'(o_grant_cnt), 32'(65533));
    check("sat_pre_busy", 32'(o_busy),      32'(0));
    pend.delete();
    m_cnt        = 65533;
    m_rsp_id     = 0;
    m_rsp_data   = int'(gray(8'h5A));
    m_last_addr  = 32'h5A;
    m_addr_known = 1;
    m_last_rdy   = '0;
    repeat (6) step(1'b1, 1'b1, 4'b0001, 32'h0000_005A);
    idle(5);
    check("sat_final_cnt", 32'(o_grant_cnt), 32'(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
